// File: rtl/core_trap_pkg.sv
// core_trap_pkg: CSR addresses, cause codes, FSM states and bit positions for the M-mode trap controller
package core_trap_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] EXC_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LADDR_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_SADDR_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;
  typedef enum logic {ST_RUN, ST_INT_ENTER} state_e;
endpackage

// File: rtl/trap_irq_arbiter.sv
// trap_irq_arbiter: fixed-priority encoder of enabled pending interrupts (MEI > MSI > MTI)
module trap_irq_arbiter
  import core_trap_pkg::*;
(
  input  logic [2:0] pend_i,
  output logic       valid_o,
  output logic [3:0] code_o
);
  // pend_i = {external, timer, software}
  always_comb begin
    valid_o = |pend_i;
    code_o  = pend_i[2] ? IRQ_MEI : pend_i[0] ? IRQ_MSI : pend_i[1] ? IRQ_MTI : 4'd0;
  end
endmodule

// File: rtl/core_trap_ctrl.sv
// core_trap_ctrl: M-mode trap CSRs plus the RUN/INT_ENTER sequencer that redirects the pipeline
module core_trap_ctrl
  import core_trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  input  logic        instr_valid_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] next_pc_ex,
  input  logic        exc_req_ex,
  input  logic [3:0]  exc_cause_ex,
  input  logic [31:0] exc_tval_ex,
  input  logic        mret_ex,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        any_interrupt_come,
  output logic        valid_interrupt_request,
  output logic        exception_occurred,
  output logic [31:0] exception_jump_addr
);
  state_e      state_q, state_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] mie_q, mie_d, mip_q, mip_d;
  logic        gie_q, gie_d, mpie_q, mpie_d;
  logic        run, take_exc, take_mret, trap, irq_valid;
  logic [3:0]  irq_code;
  logic [31:0] base;

  trap_irq_arbiter u_arb (
    .pend_i  ({mip_q[IRQ_MEI] & mie_q[IRQ_MEI], mip_q[IRQ_MTI] & mie_q[IRQ_MTI], mip_q[IRQ_MSI] & mie_q[IRQ_MSI]}),
    .valid_o (irq_valid),
    .code_o  (irq_code)
  );

  always_comb begin
    run                     = state_q == ST_RUN;
    take_exc                = run && exc_req_ex;
    take_mret               = run && mret_ex && !exc_req_ex;
    valid_interrupt_request = run && gie_q && irq_valid && instr_valid_ex && !exc_req_ex && !mret_ex;
    trap                    = take_exc || valid_interrupt_request;
    any_interrupt_come      = irq_valid;
    base                    = mtvec_q & ~32'h3;
    exception_occurred      = take_exc || take_mret || !run;
    // INT_ENTER vectors on the code latched into mcause by the accept cycle
    exception_jump_addr     = !run ? (mtvec_q[0] ? base + {26'b0, mcause_q[3:0], 2'b00} : base)
                            : take_mret ? mepc_q : base;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = gie_q;
        csr_rdata[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MIE:    csr_rdata = mie_q;
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MTVAL:  csr_rdata = mtval_q;
      CSR_MIP:    csr_rdata = mip_q;
      default:    csr_rdata = '0;
    endcase
  end

  // trap updates take precedence over a same-cycle CSR write to the same register
  always_comb begin
    state_d  = valid_interrupt_request ? ST_INT_ENTER : ST_RUN;
    mip_d    = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
    mtvec_d  = (csr_we && csr_addr == CSR_MTVEC) ? csr_wdata & ~32'h2 : mtvec_q;
    mie_d    = (csr_we && csr_addr == CSR_MIE) ? csr_wdata & MIE_MASK : mie_q;
    mepc_d   = take_exc ? pc_ex & ~32'h3
             : valid_interrupt_request ? next_pc_ex & ~32'h3
             : (csr_we && csr_addr == CSR_MEPC) ? csr_wdata & ~32'h3 : mepc_q;
    mcause_d = take_exc ? {28'b0, exc_cause_ex}
             : valid_interrupt_request ? {1'b1, 27'b0, irq_code}
             : (csr_we && csr_addr == CSR_MCAUSE) ? csr_wdata : mcause_q;
    mtval_d  = take_exc ? exc_tval_ex
             : valid_interrupt_request ? '0
             : (csr_we && csr_addr == CSR_MTVAL) ? csr_wdata : mtval_q;
    gie_d    = trap ? 1'b0 : take_mret ? mpie_q
             : (csr_we && csr_addr == CSR_MSTATUS) ? csr_wdata[MSTATUS_MIE] : gie_q;
    mpie_d   = trap ? gie_q : take_mret ? 1'b1
             : (csr_we && csr_addr == CSR_MSTATUS) ? csr_wdata[MSTATUS_MPIE] : mpie_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mie_q    <= '0;
      mip_q    <= '0;
      gie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mie_q    <= mie_d;
      mip_q    <= mip_d;
      gie_q    <= gie_d;
      mpie_q   <= mpie_d;
    end
  end
endmodule

// File: tb/tb_core_trap_ctrl.sv
// tb_core_trap_ctrl: directed stimulus, per-cycle comparison against a behavioural trap model
module tb_core_trap_ctrl;
  localparam logic [31:0] RV = 32'h0000_0080;
  logic        clk = 0, rst_n = 0;
  logic        ext_irq = 0, timer_irq = 0, sw_irq = 0, instr_valid_ex = 0;
  logic [31:0] pc_ex = 0, next_pc_ex = 0, exc_tval_ex = 0, csr_wdata = 0;
  logic        exc_req_ex = 0, mret_ex = 0, csr_we = 0;
  logic [3:0]  exc_cause_ex = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_rdata, exception_jump_addr;
  logic        any_interrupt_come, valid_interrupt_request, exception_occurred;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  core_trap_ctrl #(.MTVEC_RESET(RV)) dut (
    .clk(clk), .rst_n(rst_n), .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq),
    .instr_valid_ex(instr_valid_ex), .pc_ex(pc_ex), .next_pc_ex(next_pc_ex),
    .exc_req_ex(exc_req_ex), .exc_cause_ex(exc_cause_ex), .exc_tval_ex(exc_tval_ex),
    .mret_ex(mret_ex), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .any_interrupt_come(any_interrupt_come),
    .valid_interrupt_request(valid_interrupt_request), .exception_occurred(exception_occurred),
    .exception_jump_addr(exception_jump_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: architectural trap state as plain flags and words
  bit          m_ext, m_tim, m_sw, m_meie, m_mtie, m_msie, m_gie, m_pie, m_enter;
  logic [31:0] m_tvec = RV, m_epc = 0, m_cause = 0, m_tval = 0;
  int          m_vcode = 0;
  int          prio[3] = '{11, 3, 7};

  function automatic bit pending(input int c);
    return c == 11 ? (m_ext && m_meie) : c == 3 ? (m_sw && m_msie) : (m_tim && m_mtie);
  endfunction
  function automatic int pick();
    for (int i = 0; i < 3; i++) if (pending(prio[i])) return prio[i];
    return -1;
  endfunction
  function automatic bit f_exc();  return !m_enter && exc_req_ex; endfunction
  function automatic bit f_mret(); return !m_enter && mret_ex && !exc_req_ex; endfunction
  function automatic bit f_acc();
    return !m_enter && m_gie && pick() >= 0 && instr_valid_ex && !exc_req_ex && !mret_ex;
  endfunction
  function automatic logic [31:0] f_addr();
    logic [31:0] base = {m_tvec[31:2], 2'b00};
    if (m_enter) return m_tvec[0] ? base + 32'(4 * m_vcode) : base;
    return f_mret() ? m_epc : base;
  endfunction
  function automatic logic [31:0] f_rdata();
    case (csr_addr)
      12'h300: return (32'(m_gie) << 3) | (32'(m_pie) << 7);
      12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7) | (32'(m_msie) << 3);
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return (32'(m_ext) << 11) | (32'(m_tim) << 7) | (32'(m_sw) << 3);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_ext, m_tim, m_sw, m_meie, m_mtie, m_msie, m_gie, m_pie, m_enter} <= '0;
      m_tvec <= RV; m_epc <= 0; m_cause <= 0; m_tval <= 0;
    end else begin
      m_ext <= ext_irq; m_tim <= timer_irq; m_sw <= sw_irq;
      m_enter <= f_acc();
      if (f_acc()) m_vcode <= pick();
      if (csr_we && csr_addr == 12'h305) m_tvec <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
      if (csr_we && csr_addr == 12'h304) {m_meie, m_mtie, m_msie} <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
      if (f_exc() || f_acc()) begin
        m_pie <= m_gie; m_gie <= 0;
        m_epc <= (f_exc() ? pc_ex : next_pc_ex) & ~32'h3;
        m_cause <= f_exc() ? {28'b0, exc_cause_ex} : {1'b1, 27'b0, 4'(pick())};
        m_tval <= f_exc() ? exc_tval_ex : 32'h0;
      end else begin
        if (f_mret()) begin m_gie <= m_pie; m_pie <= 1; end
        else if (csr_we && csr_addr == 12'h300) begin m_gie <= csr_wdata[3]; m_pie <= csr_wdata[7]; end
        if (csr_we && csr_addr == 12'h341) m_epc <= csr_wdata & ~32'h3;
        if (csr_we && csr_addr == 12'h342) m_cause <= csr_wdata;
        if (csr_we && csr_addr == 12'h343) m_tval <= csr_wdata;
      end
    end
  end

  always @(negedge clk) begin
    check("any_irq", 32'(any_interrupt_come), 32'(pick() >= 0));
    check("irq_req", 32'(valid_interrupt_request), 32'(f_acc()));
    check("exc_occ", 32'(exception_occurred), 32'(f_exc() || f_mret() || m_enter));
    check("jump_addr", exception_jump_addr, f_addr());
    check("rdata", csr_rdata, f_rdata());
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); #1; endtask
  task automatic wcsr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d; nxt(); csr_we = 0;
  endtask
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a; #1; check(name, csr_rdata, exp);
  endtask

  initial begin
    nxt(); nxt(); rst_n = 1;
    mid();
    rd("rst_mtvec", 12'h305, RV);
    rd("rst_mstatus", 12'h300, 0);
    rd("rst_mie", 12'h304, 0);
    check("rst_addr", exception_jump_addr, RV);
    check("rst_eo", 32'(exception_occurred), 0);
    check("rst_vir", 32'(valid_interrupt_request), 0);
    nxt();
    wcsr(12'h305, 32'h100);
    exc_req_ex = 1; exc_cause_ex = 2; pc_ex = 32'h40; exc_tval_ex = 32'hDEAD;
    mid();
    check("ill_eo", 32'(exception_occurred), 1);
    check("ill_addr", exception_jump_addr, 32'h100);
    nxt(); exc_req_ex = 0;
    rd("ill_mepc", 12'h341, 32'h40);
    rd("ill_mcause", 12'h342, 32'h2);
    rd("ill_mtval", 12'h343, 32'hDEAD);
    rd("ill_mstatus", 12'h300, 0);
    wcsr(12'h305, 32'h201); wcsr(12'h304, 32'h80); wcsr(12'h300, 32'h8);
    instr_valid_ex = 1; next_pc_ex = 32'h88; timer_irq = 1;
    mid(); check("tmr_early", 32'(valid_interrupt_request), 0);
    nxt(); mid(); check("tmr_vir", 32'(valid_interrupt_request), 1);
    nxt(); timer_irq = 0;
    mid();
    check("tmr_eo", 32'(exception_occurred), 1);
    check("tmr_addr", exception_jump_addr, 32'h21C);
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mepc", 12'h341, 32'h88);
    nxt(); mid(); check("tmr_done", 32'(exception_occurred), 0);
    wcsr(12'h305, 32'h100); wcsr(12'h304, 32'h800);
    ext_irq = 1; nxt(); mid();
    check("gate_any", 32'(any_interrupt_come), 1);
    check("gate_vir", 32'(valid_interrupt_request), 0);
    wcsr(12'h300, 32'h8);
    exc_req_ex = 1; exc_cause_ex = 11; pc_ex = 32'h60;
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h998;
    mid();
    check("sim_eo", 32'(exception_occurred), 1);
    check("sim_vir", 32'(valid_interrupt_request), 0);
    check("sim_addr", exception_jump_addr, 32'h100);
    nxt(); exc_req_ex = 0; csr_we = 0;
    rd("sim_mepc", 12'h341, 32'h60);
    rd("sim_mcause", 12'h342, 32'hB);
    mret_ex = 1; mid();
    check("mret_eo", 32'(exception_occurred), 1);
    check("mret_addr", exception_jump_addr, 32'h60);
    nxt(); mret_ex = 0;
    mid(); check("ext_vir", 32'(valid_interrupt_request), 1);
    nxt(); ext_irq = 0;
    mid();
    check("ext_addr", exception_jump_addr, 32'h100);
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    nxt();
    wcsr(12'h341, 32'h1234);
    mret_ex = 1; mid(); check("new_mepc", exception_jump_addr, 32'h1234);
    nxt(); mret_ex = 0; instr_valid_ex = 0;
    wcsr(12'h304, 32'h8); sw_irq = 1;
    for (int i = 0; i < 3; i++) begin nxt(); mid(); check("hold_vir", 32'(valid_interrupt_request), 0); end
    instr_valid_ex = 1; #1; check("sw_vir", 32'(valid_interrupt_request), 1);
    nxt(); mid(); check("sw_eo", 32'(exception_occurred), 1);
    rst_n = 0; #1;
    check("abort_eo", 32'(exception_occurred), 0);
    check("abort_addr", exception_jump_addr, RV);
    sw_irq = 0; instr_valid_ex = 0;
    nxt(); rst_n = 1; nxt(); mid();
    check("post_eo", 32'(exception_occurred), 0);
    rd("post_mcause", 12'h342, 0);
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
